// File: rtl/demux1x8_stage.sv
`timescale 1ns/1ps
// Registered 1-to-8 steering stage: valid/ready input, one-hot destination valid
// on a shared data bus, two-entry skid buffer for full throughput with registered in_ready.
//
// state | meaning
// EMPTY | no word buffered, out_valid = 0
// ONE   | main register holds the head word
// TWO   | main holds head, skid holds the next word, in_ready low
module demux1x8_stage #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic [2:0]       in_sel,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       occ
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       occ_q, occ_d;
  logic [width-1:0] main_data_q, main_data_d;
  logic [2:0]       main_sel_q, main_sel_d;
  logic [width-1:0] skid_data_q, skid_data_d;
  logic [2:0]       skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  // Only the selected destination's ready can complete a transfer.
  assign out_fire = (occ_q != EMPTY) & out_ready[main_sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    if (flush) begin
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (in_fire) begin
            occ_d       = ONE;
            main_data_d = in_data;
            main_sel_d  = in_sel;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_sel_d  = in_sel;
          end else if (in_fire) begin
            occ_d       = TWO;
            skid_data_d = in_data;
            skid_sel_d  = in_sel;
          end else if (out_fire) begin
            occ_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            occ_d       = ONE;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
    in_ready_d = (occ_d != TWO);
  end

  always_comb begin
    out_valid = (occ_q != EMPTY) ? (8'b1 << main_sel_q) : 8'b0;
    out_data  = main_data_q;
    occ       = occ_q;
    in_ready  = in_ready_q;
  end

endmodule

// File: tb/tb_demux1x8_stage.sv
`timescale 1ns/1ps
// Self-checking bench for demux1x8_stage: directed scenarios plus randomized
// traffic compared against an in-order FIFO model of capacity two.
module tb_demux1x8_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_sel = '0;
  logic [7:0] out_valid;
  logic [7:0] out_ready = '0;
  logic [7:0] out_data;
  logic [1:0] occ;

  int asserts = 0;
  int fails = 0;

  demux1x8_stage #(.width(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] sel; logic [7:0] data; } ent_t;
  ent_t       q[$];
  logic       m_ready;
  logic [7:0] m_last;

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    v = 8'h00;
    if (q.size() > 0) v[q[0].sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(q.size());
  endfunction

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic tick();
    bit   inf, outf;
    ent_t e;
    inf  = in_valid && m_ready;
    outf = (q.size() > 0) && out_ready[q[0].sel];
    e.sel  = in_sel;
    e.data = in_data;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(e);
    end
    m_ready = (q.size() != 2);
    if (q.size() > 0) m_last = q[0].data;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q.delete();
    m_ready = 1'b0;
    m_last = 8'h00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    flush = 0; in_valid = 0; out_ready = 8'hFF;
    apply_reset();
    asserts++;
    if ({in_ready, out_valid, out_data, occ} !== 19'h0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b v=%h d=%h occ=%0d, want all zero", in_ready, out_valid, out_data, occ);
    end
    rst_n = 1'b1;
    #1;
    asserts++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    asserts++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream(input string name);
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_sel = 3'(i); in_data = 8'h10 + 8'(i);
      tick();
      asserts++;
      if (out_valid !== (8'h01 << i) || out_data !== 8'h10 + 8'(i) || occ !== 2'd1 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s_%0d: got v=%h d=%h occ=%0d rdy=%b want v=%h d=%h occ=1 rdy=1",
                 name, i, out_valid, out_data, occ, in_ready, 8'h01 << i, 8'h10 + 8'(i));
      end
    end
    in_valid = 0;
    tick();
    asserts++;
    if (out_valid !== 8'h00 || occ !== 2'd0 || out_data !== 8'h17) begin
      fails++;
      $display("FAIL %s_drain: got v=%h occ=%0d d=%h want v=00 occ=0 d=17", name, out_valid, occ, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] seq_d [7] = '{8'hA1, 8'hB2, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
    logic [7:0] seq_r [7] = '{8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bit         seq_v [7] = '{1, 1, 1, 1, 0, 0, 0};
    in_sel = 3'd3;
    for (int i = 0; i < 7; i++) begin
      in_valid = seq_v[i]; in_data = seq_d[i]; out_ready = seq_r[i];
      // C stays offered until it is actually taken
      if (i == 4 && q.size() > 0 && q[q.size()-1].data != 8'hC3) in_valid = 1;
      tick();
      asserts++;
      if (out_valid !== exp_valid() || out_data !== m_last || occ !== exp_occ() || in_ready !== m_ready) begin
        fails++;
        $display("FAIL backpressure_%0d: got v=%h d=%h occ=%0d rdy=%b want v=%h d=%h occ=%0d rdy=%b",
                 i, out_valid, out_data, occ, in_ready, exp_valid(), m_last, exp_occ(), m_ready);
      end
      if (i == 1) begin
        asserts++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'hA1) begin
          fails++;
          $display("FAIL backpressure_full: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a1", occ, in_ready, out_data);
        end
      end
    end
    asserts++;
    if (occ !== 2'd0) begin
      fails++;
      $display("FAIL backpressure_end: got occ=%0d want 0", occ);
    end
  endtask

  task automatic test_wrong_dest();
    out_ready = 8'h00;
    in_valid = 1; in_sel = 3'd5; in_data = 8'h5A;
    tick();
    in_valid = 0; out_ready = 8'hDF;
    for (int i = 0; i < 4; i++) begin
      tick();
      asserts++;
      if (out_valid !== 8'h20 || out_data !== 8'h5A || occ !== 2'd1) begin
        fails++;
        $display("FAIL wrong_dest_%0d: got v=%h d=%h occ=%0d want v=20 d=5a occ=1", i, out_valid, out_data, occ);
      end
    end
    out_ready = 8'hFF;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 8'h00; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_sel = 3'(i + 1); in_data = 8'hE0 + 8'(i);
      tick();
    end
    flush = 1; in_data = 8'hEE; in_sel = 3'd6;
    tick();
    flush = 0; in_valid = 0;
    asserts++;
    if (occ !== 2'd0 || out_valid !== 8'h00 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush: got occ=%0d v=%h rdy=%b want occ=0 v=00 rdy=1", occ, out_valid, in_ready);
    end
    out_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      asserts++;
      if (out_valid !== 8'h00 || out_data !== m_last) begin
        fails++;
        $display("FAIL flush_ghost_%0d: got v=%h d=%h want v=00 d=%h", i, out_valid, out_data, m_last);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 8'h00; in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_sel = 3'(i); in_data = 8'h70 + 8'(i);
      tick();
    end
    asserts++;
    if (occ !== 2'd2) begin
      fails++;
      $display("FAIL async_setup: got occ=%0d want 2", occ);
    end
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if (out_valid !== 8'h00 || in_ready !== 1'b0 || occ !== 2'd0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: got v=%h rdy=%b occ=%0d d=%h want 00/0/0/00", out_valid, in_ready, occ, out_data);
    end
    apply_reset();
    rst_n = 1'b1;
    tick();
    test_stream("recover");
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      in_sel    = 3'($urandom_range(7));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
      tick();
      asserts++;
      if (out_valid !== exp_valid() || out_data !== m_last || occ !== exp_occ() || in_ready !== m_ready) begin
        fails++;
        $display("FAIL random_%0d: got v=%h d=%h occ=%0d rdy=%b want v=%h d=%h occ=%0d rdy=%b",
                 i, out_valid, out_data, occ, in_ready, exp_valid(), m_last, exp_occ(), m_ready);
      end
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_stream("stream");
    test_backpressure();
    test_wrong_dest();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
